// File: rtl/ifu_prefetch_pkg.sv
// rtl/ifu_prefetch_pkg.sv - shared defaults and helpers for the instruction prefetch stage
package ifu_prefetch_pkg;

  localparam int PC_SIZE_DFLT       = 32;
  localparam int INSTR_SIZE_DFLT    = 32;
  localparam int IFU_PF_DEPTH_DFLT  = 4;
  localparam int IFU_PF_OUTSTD_DFLT = 2;
  localparam int PC_STEP            = 4;

  // Width of a counter that must hold the values 0..n inclusive.
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/ifu_prefetch_if.sv
// rtl/ifu_prefetch_if.sv - fetch bus request/response interface between IFU (master) and ITCM/bus (slave)
interface ifu_prefetch_if
  import ifu_prefetch_pkg::*;
#(
  parameter int PC_SIZE    = PC_SIZE_DFLT,
  parameter int INSTR_SIZE = INSTR_SIZE_DFLT
);

  logic                  ifu_req_valid;
  logic                  ifu_req_ready;
  logic [PC_SIZE-1:0]    ifu_req_pc;
  logic                  ifu_rsp_valid;
  logic                  ifu_rsp_ready;
  logic [INSTR_SIZE-1:0] ifu_rsp_instr;

  modport master (
    output ifu_req_valid, ifu_req_pc, ifu_rsp_ready,
    input  ifu_req_ready, ifu_rsp_valid, ifu_rsp_instr
  );

  modport slave (
    input  ifu_req_valid, ifu_req_pc, ifu_rsp_ready,
    output ifu_req_ready, ifu_rsp_valid, ifu_rsp_instr
  );

endinterface

// File: rtl/ifu_pf_fifo.sv
// rtl/ifu_pf_fifo.sv - synchronous power-of-2 FIFO with push/pop/clear, count and full/empty flags
module ifu_pf_fifo
  import ifu_prefetch_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int DEPTH = IFU_PF_DEPTH_DFLT,
  localparam int CNT_W = cnt_width(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  input  logic             i_clear,
  output logic [WIDTH-1:0] o_rdata,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_full,
  output logic             o_empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [CNT_W-1:0] r_cnt;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_cnt == CNT_W'(DEPTH));
  assign o_empty = (r_cnt == '0);
  assign o_cnt   = r_cnt;
  assign o_rdata = r_mem[r_rd_ptr];
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_cnt    <= '0;
    end else if (i_clear) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_cnt    <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_cnt <= r_cnt + CNT_W'(w_push) - CNT_W'(w_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push & ~i_clear) r_mem[r_wr_ptr] <= i_wdata;
  end

endmodule

// File: rtl/ifu_prefetch.sv
// rtl/ifu_prefetch.sv - prefetching fetch stage with outstanding-request credits and flush drop logic
// Optional feature: IFU_PREFETCH_PERF_EN adds saturating stall/drop performance counters.
module ifu_prefetch
  import ifu_prefetch_pkg::*;
#(
  parameter int PC_SIZE    = PC_SIZE_DFLT,
  parameter int INSTR_SIZE = INSTR_SIZE_DFLT,
  parameter int FIFO_DEPTH = IFU_PF_DEPTH_DFLT,
  parameter int MAX_OUTSTD = IFU_PF_OUTSTD_DFLT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [PC_SIZE-1:0]    i_pc_rtvec,
  ifu_prefetch_if.master        bus,
  output logic                  o_ifu_o_valid,
  input  logic                  i_ifu_o_ready,
  output logic [INSTR_SIZE-1:0] o_ifu_o_ir,
  output logic [PC_SIZE-1:0]    o_ifu_o_pc,
  input  logic                  i_pipe_flush_req,
  input  logic [PC_SIZE-1:0]    i_pipe_flush_pc,
  output logic                  o_pipe_flush_ack
`ifdef IFU_PREFETCH_PERF_EN
  ,
  output logic [31:0]           o_perf_stall_cnt,
  output logic [31:0]           o_perf_drop_cnt
`endif
);

  localparam int OS_W  = cnt_width(MAX_OUTSTD);
  localparam int FC_W  = cnt_width(FIFO_DEPTH);
  localparam int SUM_W = cnt_width(FIFO_DEPTH + MAX_OUTSTD);

  logic [PC_SIZE-1:0] r_fetch_pc;
  logic [PC_SIZE-1:0] r_wr_pc;
  logic [OS_W-1:0]    r_outstd_cnt;
  logic [OS_W-1:0]    r_drop_cnt;

  logic [PC_SIZE-1:0]    w_rtvec_al;
  logic [PC_SIZE-1:0]    w_flush_pc_al;
  logic [SUM_W-1:0]      w_credit_sum;
  logic                  w_flush;
  logic                  w_req_valid;
  logic                  w_req_hsk;
  logic                  w_rsp_hsk;
  logic                  w_drop;
  logic                  w_push;
  logic                  w_pop;
  logic [FC_W-1:0]       w_fifo_cnt;
  logic                  w_fifo_full;
  logic                  w_fifo_empty;
  logic [INSTR_SIZE-1:0] w_head_ir;
  logic [PC_SIZE-1:0]    w_head_pc;

  assign w_rtvec_al    = i_pc_rtvec & ~PC_SIZE'(3);
  assign w_flush_pc_al = i_pipe_flush_pc & ~PC_SIZE'(3);
  assign w_flush       = i_pipe_flush_req;

  // Credits: never exceed MAX_OUTSTD in flight, and reserve a FIFO slot for every response.
  assign w_credit_sum = SUM_W'(r_outstd_cnt) + SUM_W'(w_fifo_cnt);
  assign w_req_valid  = ~w_flush & (r_outstd_cnt < OS_W'(MAX_OUTSTD))
                      & (w_credit_sum < SUM_W'(FIFO_DEPTH));
  assign w_req_hsk    = w_req_valid & bus.ifu_req_ready;
  assign w_rsp_hsk    = bus.ifu_rsp_valid;
  assign w_drop       = w_rsp_hsk & (w_flush | (r_drop_cnt != '0));
  assign w_push       = w_rsp_hsk & ~w_drop;
  assign w_pop        = o_ifu_o_valid & i_ifu_o_ready;

  assign bus.ifu_req_valid = w_req_valid;
  assign bus.ifu_req_pc    = r_fetch_pc;
  assign bus.ifu_rsp_ready = 1'b1;

  assign o_ifu_o_valid    = ~w_fifo_empty & ~w_flush;
  assign o_ifu_o_ir       = w_head_ir;
  assign o_ifu_o_pc       = w_head_pc;
  assign o_pipe_flush_ack = 1'b1;

  ifu_pf_fifo #(
    .WIDTH (PC_SIZE + INSTR_SIZE),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_wdata ({r_wr_pc, bus.ifu_rsp_instr}),
    .i_pop   (w_pop),
    .i_clear (w_flush),
    .o_rdata ({w_head_pc, w_head_ir}),
    .o_cnt   (w_fifo_cnt),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_pc   <= w_rtvec_al;
      r_wr_pc      <= w_rtvec_al;
      r_outstd_cnt <= '0;
      r_drop_cnt   <= '0;
    end else begin
      r_outstd_cnt <= r_outstd_cnt + OS_W'(w_req_hsk) - OS_W'(w_rsp_hsk);
      if (w_flush) begin
        // Every response still in flight after this cycle belongs to the old stream.
        r_fetch_pc <= w_flush_pc_al;
        r_wr_pc    <= w_flush_pc_al;
        r_drop_cnt <= r_outstd_cnt - OS_W'(w_rsp_hsk);
      end else begin
        if (w_req_hsk) r_fetch_pc <= r_fetch_pc + PC_SIZE'(PC_STEP);
        if (w_push)    r_wr_pc    <= r_wr_pc + PC_SIZE'(PC_STEP);
        if (w_drop)    r_drop_cnt <= r_drop_cnt - OS_W'(1);
      end
    end
  end

`ifdef IFU_PREFETCH_PERF_EN
  logic [31:0] r_perf_stall_cnt;
  logic [31:0] r_perf_drop_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_perf_stall_cnt <= '0;
      r_perf_drop_cnt  <= '0;
    end else begin
      if (i_ifu_o_ready & w_fifo_empty & ~w_flush & (r_perf_stall_cnt != '1))
        r_perf_stall_cnt <= r_perf_stall_cnt + 32'd1;
      if (w_drop & (r_perf_drop_cnt != '1))
        r_perf_drop_cnt <= r_perf_drop_cnt + 32'd1;
    end
  end

  assign o_perf_stall_cnt = r_perf_stall_cnt;
  assign o_perf_drop_cnt  = r_perf_drop_cnt;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(w_push && w_fifo_full));
      assert (!(bus.ifu_rsp_valid && (r_outstd_cnt == '0)));
    end
  end

endmodule

// File: tb/tb_ifu_prefetch.sv
// tb/tb_ifu_prefetch.sv - scoreboard bench for ifu_prefetch with a 1-cycle-latency bus model
module tb_ifu_prefetch;
  import ifu_prefetch_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] pc_rtvec;
  logic        o_ready;
  logic        flush_req;
  logic [31:0] flush_pc;
  logic        o_valid;
  logic [31:0] o_ir;
  logic [31:0] o_pc;
  logic        flush_ack;
`ifdef IFU_PREFETCH_PERF_EN
  logic [31:0] perf_stall;
  logic [31:0] perf_drop;
  logic [31:0] drop_snap;
`endif

  int          n_checks = 0;
  int          n_pass   = 0;
  int          req_cnt  = 0;
  int          mon_pops = 0;
  bit          rsp_en;
  logic [31:0] exp_q[$];
  logic [31:0] bus_q[$];
  logic [31:0] mon_exp;

  always #5 clk = ~clk;

  ifu_prefetch_if #(.PC_SIZE(32), .INSTR_SIZE(32)) bus ();

  ifu_prefetch dut (
    .clk              (clk),
`ifdef IFU_PREFETCH_PERF_EN
    .o_perf_stall_cnt (perf_stall),
    .o_perf_drop_cnt  (perf_drop),
`endif
    .rst              (rst),
    .i_pc_rtvec       (pc_rtvec),
    .bus              (bus.master),
    .o_ifu_o_valid    (o_valid),
    .i_ifu_o_ready    (o_ready),
    .o_ifu_o_ir       (o_ir),
    .o_ifu_o_pc       (o_pc),
    .i_pipe_flush_req (flush_req),
    .i_pipe_flush_pc  (flush_pc),
    .o_pipe_flush_ack (flush_ack)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hDEAD_BEEF;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic check_min(input string name, input int act, input int min_v);
    n_checks++;
    if (act >= min_v) n_pass++;
    else $display("FAIL %s: got %0d, expected at least %0d", name, act, min_v);
  endtask

  task automatic expect_from(input logic [31:0] start, input int n);
    exp_q.delete();
    for (int i = 0; i < n; i++) exp_q.push_back(start + 32'(4 * i));
    mon_pops = 0;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Called at a negedge; returns at the negedge of the cycle after the flush.
  task automatic do_flush(input logic [31:0] pc, input logic [31:0] first_pc);
    flush_req = 1'b1;
    flush_pc  = pc;
    expect_from(first_pc, 64);
    @(negedge clk);
    flush_req = 1'b0;
  endtask

  // Bus slave: accepts every request, answers in order one cycle later unless held by rsp_en.
  initial begin
    bus.ifu_rsp_valid = 1'b0;
    bus.ifu_rsp_instr = '0;
    forever begin
      @(negedge clk);
      #4;
      if (rst) begin
        bus_q.delete();
      end else begin
        if (bus.ifu_rsp_valid) void'(bus_q.pop_front());
        if (bus.ifu_req_valid && bus.ifu_req_ready) begin
          bus_q.push_back(bus.ifu_req_pc);
          req_cnt++;
        end
      end
      @(posedge clk);
      #1;
      if (rsp_en && bus_q.size() > 0) begin
        bus.ifu_rsp_valid = 1'b1;
        bus.ifu_rsp_instr = mem_word(bus_q[0]);
      end else begin
        bus.ifu_rsp_valid = 1'b0;
      end
    end
  end

  // Monitor: every accepted instruction must match the head of the expected stream.
  initial begin
    forever begin
      @(negedge clk);
      #4;
      if (!rst && o_valid && o_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL mon_unexpected: got pc %h, expected no output", o_pc);
        end else begin
          mon_exp = exp_q.pop_front();
          check("o_pc", o_pc, mon_exp);
          check("o_ir", o_ir, mem_word(mon_exp));
          mon_pops++;
        end
      end
    end
  end

  initial begin
    pc_rtvec  = 32'h8000_0002;
    o_ready   = 1'b0;
    flush_req = 1'b0;
    flush_pc  = '0;
    rsp_en    = 1'b1;
    bus.ifu_req_ready = 1'b1;
    rst = 1'b1;
    cycles(3);

    // Reset vector alignment and streaming
    rst     = 1'b0;
    o_ready = 1'b1;
    expect_from(32'h8000_0000, 64);
    #4;
    check("rst_req_valid", 32'(bus.ifu_req_valid), 32'd1);
    check("rst_req_pc", bus.ifu_req_pc, 32'h8000_0000);
    check("rst_o_valid", 32'(o_valid), 32'd0);
    check("flush_ack", 32'(flush_ack), 32'd1);
    cycles(12);
    check_min("p1_pops", mon_pops, 8);

    // Back-pressure: exactly FIFO_DEPTH requests, then one per pop
    @(negedge clk);
    o_ready = 1'b0;
    req_cnt = 0;
    do_flush(32'h200, 32'h200);
    cycles(12);
    #4;
    check("bp_req_cnt", 32'(req_cnt), 32'd4);
    check("bp_req_valid", 32'(bus.ifu_req_valid), 32'd0);
    @(negedge clk);
    o_ready = 1'b1;
    @(negedge clk);
    o_ready = 1'b0;
    cycles(8);
    #4;
    check("bp_req_cnt_after_pop", 32'(req_cnt), 32'd5);
    check("bp_pops", 32'(mon_pops), 32'd1);

    // Two requests outstanding, then flush to 0x100
    @(negedge clk);
    o_ready = 1'b1;
    rsp_en  = 1'b0;
    cycles(10);
    #4;
    check("f1_outstd", 32'(bus_q.size()), 32'd2);
    check("f1_o_valid_drained", 32'(o_valid), 32'd0);
`ifdef IFU_PREFETCH_PERF_EN
    check_min("perf_stall", int'(perf_stall), 1);
    drop_snap = perf_drop;
`endif
    @(negedge clk);
    rsp_en = 1'b1;
    do_flush(32'h100, 32'h100);
    cycles(10);
    #4;
    check_min("f1_pops", mon_pops, 4);
`ifdef IFU_PREFETCH_PERF_EN
    check("f1_perf_drop", perf_drop - drop_snap, 32'd2);
`endif

    // Flush coinciding with a response while two are outstanding
    @(negedge clk);
    rsp_en = 1'b0;
    cycles(10);
    #4;
    check("f2_outstd", 32'(bus_q.size()), 32'd2);
`ifdef IFU_PREFETCH_PERF_EN
    drop_snap = perf_drop;
`endif
    @(negedge clk);
    rsp_en = 1'b1;
    @(negedge clk);
    do_flush(32'h300, 32'h300);
    #4;
    check("f2_o_valid_p1", 32'(o_valid), 32'd0);
    @(negedge clk);
    #4;
    check("f2_o_valid_p2", 32'(o_valid), 32'd0);
    @(negedge clk);
    #4;
    check("f2_o_valid_p3", 32'(o_valid), 32'd1);
    cycles(8);
    #4;
    check_min("f2_pops", mon_pops, 4);
`ifdef IFU_PREFETCH_PERF_EN
    check("f2_perf_drop", perf_drop - drop_snap, 32'd2);
`endif

    // PC wrap, with an unaligned flush target
    @(negedge clk);
    do_flush(32'hFFFF_FFFA, 32'hFFFF_FFF8);
    cycles(10);
    #4;
    check_min("wrap_pops", mon_pops, 5);

    // Reset with three entries buffered and one request in flight
    @(negedge clk);
    o_ready = 1'b0;
    cycles(10);
    o_ready = 1'b1;
    rsp_en  = 1'b0;
    @(negedge clk);
    o_ready = 1'b0;
    cycles(3);
    #4;
    check("r2_pre_o_valid", 32'(o_valid), 32'd1);
    @(negedge clk);
    rst      = 1'b1;
    pc_rtvec = 32'h0000_1236;
    exp_q.delete();
    @(negedge clk);
    rst     = 1'b0;
    rsp_en  = 1'b1;
    o_ready = 1'b1;
    expect_from(32'h0000_1234, 64);
    #4;
    check("r2_o_valid", 32'(o_valid), 32'd0);
    check("r2_req_valid", 32'(bus.ifu_req_valid), 32'd1);
    check("r2_req_pc", bus.ifu_req_pc, 32'h0000_1234);
    @(negedge clk);
    #4;
    check("r2_req_valid_2nd", 32'(bus.ifu_req_valid), 32'd1);
    check("r2_req_pc_2nd", bus.ifu_req_pc, 32'h0000_1238);
    cycles(8);
    #4;
    check_min("r2_pops", mon_pops, 5);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ifu_prefetch.md
Name: ifu_prefetch

Overview:
Parametrised successor to the single-entry fetch stage. Decouples instruction fetch from EXU with an in-order prefetch FIFO and up to MAX_OUTSTD in-flight bus requests. Sits between the ITCM/bus fetch port (req/rsp) and the EXU IR interface, and handles pipeline flushes by discarding stale responses.

Parameters:
- PC_SIZE, 32, width of the PC and of the fetch address.
- INSTR_SIZE, 32, instruction width.
- FIFO_DEPTH, 4, number of prefetch buffer entries; must be a power of 2 and at least 2.
- MAX_OUTSTD, 2, maximum number of requests issued but not yet responded; range 1..FIFO_DEPTH.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous reset, active-high.
- pc_rtvec  in  PC_SIZE  reset PC; sampled while rst=1.
- ifu_req_valid  out  1  fetch request valid.
- ifu_req_ready  in  1  bus accepts the request.
- ifu_req_pc  out  PC_SIZE  fetch address; word-aligned.
- ifu_rsp_valid  in  1  fetch response valid; responses return in order.
- ifu_rsp_ready  out  1  tied to 1.
- ifu_rsp_instr  in  INSTR_SIZE  fetched instruction.
- ifu_o_valid  out  1  instruction available to EXU.
- ifu_o_ready  in  1  EXU accepts the instruction.
- ifu_o_ir  out  INSTR_SIZE  instruction at the FIFO head.
- ifu_o_pc  out  PC_SIZE  PC of the head instruction.
- pipe_flush_req  in  1  redirect request.
- pipe_flush_pc  in  PC_SIZE  redirect target.
- pipe_flush_ack  out  1  tied to 1.

Behaviour:
State elements:
- fetch_pc: next address to request.
- wr_pc: PC of the next response to be buffered.
- outstd_cnt: in-flight requests; $clog2(MAX_OUTSTD+1) bits.
- drop_cnt: stale responses still to discard; same width as outstd_cnt.
- FIFO: entries of {pc, instr}, with count, read pointer and write pointer.

Reset (rst=1 at a clock edge):
- fetch_pc <= wr_pc <= {pc_rtvec[PC_SIZE-1:2], 2'b00}.
- outstd_cnt, drop_cnt, FIFO count and pointers all <= 0.
- In the cycle after reset: ifu_req_valid=0 only if a credit is lacking (never the case), so requesting starts immediately; ifu_o_valid=0.
- Reset asserted mid-operation abandons all in-flight state. Responses arriving after reset are not dropped; the bus is reset together with this block.

Request issue:
- ifu_req_valid = ~pipe_flush_req & (outstd_cnt < MAX_OUTSTD) & (outstd_cnt + fifo_cnt < FIFO_DEPTH).
- The credit rule guarantees that every response has a free FIFO slot.
- On req handshake: fetch_pc += 4 (wraps modulo 2^PC_SIZE).
- ifu_req_pc = fetch_pc.

Response handling (ifu_rsp_ready always 1):
- If drop_cnt != 0: discard the response and decrement drop_cnt.
- Else: push {wr_pc, ifu_rsp_instr} into the FIFO and set wr_pc += 4.
- outstd_cnt_nxt = outstd_cnt + req_hsk - rsp_hsk. Issuing and receiving in the same cycle is legal.

Output:
- ifu_o_valid = (fifo_cnt != 0) & ~pipe_flush_req.
- ifu_o_ir and ifu_o_pc are taken from the FIFO head.
- Pop on ifu_o_valid & ifu_o_ready.
- Push and pop in the same cycle are legal; the count is unchanged.
- Zero-latency bypass is not supported: minimum latency from response to ifu_o_valid is 1 cycle.

Flush (pipe_flush_req=1):
- Acknowledged in the same cycle.
- No request is issued and no pop occurs in that cycle.
- The FIFO is cleared; a response arriving in that cycle is discarded.
- fetch_pc <= wr_pc <= {pipe_flush_pc[PC_SIZE-1:2], 2'b00}.
- drop_cnt <= outstd_cnt - rsp_hsk, counting every in-flight response including those already marked for drop; outstd_cnt updates normally.
- Back-to-back flushes: the last one wins, and drop_cnt is recomputed each time.

Illegal conditions (flagged by simulation assertions):
- A FIFO push while full.
- rsp_valid while outstd_cnt == 0.

Optional Feature:
Macro IFU_PREFETCH_PERF_EN.
- With it: extra outputs perf_stall_cnt (32 bits) and perf_drop_cnt (32 bits), both reset to 0 and saturating.
  - perf_stall_cnt increments each cycle that ifu_o_ready=1 & fifo_cnt==0 & ~pipe_flush_req.
  - perf_drop_cnt increments on every discarded response.
- Without it: the ports and counters do not exist, and behaviour is otherwise identical.

Decomposition:
- Shared constants come from defines.v: `PC_SIZE, `INSTR_SIZE, `INSTR_NOP. Add `IFU_PF_DEPTH_DFLT and `IFU_PF_OUTSTD_DFLT there.
- Natural sub-module: ifu_pf_fifo, a synchronous FIFO parametrised in width and depth, with push/pop/clear, count output, and full/empty flags.
- Top level holds the PC, credit and drop logic.

Test Plan:
- Reset with pc_rtvec=0x8000_0002, bus always ready, 1-cycle response -> first ifu_req_pc=0x8000_0000; ifu_o_pc sequence 0x8000_0000, 0x8000_0004, ...
- ifu_o_ready=0 held, FIFO_DEPTH=4 -> exactly 4 requests issued, then ifu_req_valid=0; ifu_o_ready=1 for one cycle -> exactly one new request.
- 2 requests outstanding, flush to 0x100 -> both late responses discarded (perf_drop_cnt=2 if enabled); next ifu_o_pc=0x100 with the instruction fetched from 0x100.
- Flush in the same cycle as a response arrives with outstd_cnt=2 -> drop_cnt=1, that response is also discarded, and FIFO count=0 afterwards.
- fetch_pc=0xFFFF_FFFC -> next ifu_req_pc=0x0000_0000 (wrap).
- rst asserted with FIFO holding 3 entries -> next cycle ifu_o_valid=0, outstd_cnt=0, ifu_req_pc=pc_rtvec aligned.
